m_imem_loader: RTL and testbench

- Serial program loader. It is the writer side of the instruction-memory port: a UART receiver assembles 32-bit words from a host byte stream and writes them into the processor's instruction memory over the memory's address / write-enable / write-data interface.
- Holds the processor in reset until the image is fully written.
- Sits between the board RX pin, the instruction memory write port and the processor reset input.

---
 rtl/m_imem_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_m_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_imem_loader.sv
// Serial program loader: UART 8N1 bytes -> little-endian words -> instruction memory writes.
// Holds the processor in reset (r_busy) until the image is in. Define LOADER_CSUM_EN to require a trailing checksum word.
module m_imem_loader #(
  parameter int unsigned SERIAL_WCNT = 434,
  parameter int unsigned MAX_WORDS   = 4096
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_rxd,
  output logic [11:0] r_addr,
  output logic        r_we,
  output logic [31:0] r_din,
  output logic        r_busy,
  output logic        r_done,
  output logic        r_err
);
  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = $clog2(SERIAL_WCNT);
  localparam int unsigned NW   = $clog2(MAX_WORDS + 1);
  localparam int unsigned HALF = SERIAL_WCNT / 2;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
`ifdef LOADER_CSUM_EN
  typedef enum logic [2:0] {L_HDR, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;
`else
  typedef enum logic [2:0] {L_HDR, L_DATA, L_DONE, L_ERR} ld_state_t;
`endif

  // RX line synchroniser plus one extra stage for falling-edge detection
  logic rxd_meta, rxd_sync, rxd_prev;
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= w_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  rx_state_t     rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_sh, rx_sh_d;
  logic          byte_valid, byte_valid_d;
  logic          frame_err, frame_err_d;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_bit     <= rx_bit_d;
      rx_sh      <= rx_sh_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  // Start bit is re-checked at half a bit; data and stop are sampled mid-bit
  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt + CW'(1);
    rx_bit_d     = rx_bit;
    rx_sh_d      = rx_sh;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev && !rxd_sync) rx_state_d = R_START;
      end
      R_START: begin
        if (rx_cnt == CW'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt == CW'(SERIAL_WCNT - 1)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxd_sync, rx_sh[7:1]};
          rx_bit_d = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt == CW'(SERIAL_WCNT - 1)) begin
          rx_cnt_d     = '0;
          rx_state_d   = R_IDLE;
          byte_valid_d = rxd_sync;
          frame_err_d  = !rxd_sync;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  ld_state_t     ld_state, ld_state_d;
  logic [1:0]    byte_idx, byte_idx_d;
  logic [23:0]   asm_q, asm_d;
  logic [NW-1:0] n_q, n_d, wcnt_q, wcnt_d;
  logic [DW-1:0] word_c;
  logic          active_c, word_last_c;
  logic          we_d, busy_d, done_d, err_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_d;
`ifdef LOADER_CSUM_EN
  logic [DW-1:0] acc_q, acc_d;
`endif

  assign word_c      = {rx_sh, asm_q};
  assign active_c    = (ld_state != L_DONE) && (ld_state != L_ERR);
  assign word_last_c = byte_valid && (byte_idx == 2'd3);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      ld_state <= L_HDR;
      byte_idx <= '0;
      asm_q    <= '0;
      n_q      <= '0;
      wcnt_q   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef LOADER_CSUM_EN
      acc_q    <= '0;
`endif
    end else begin
      ld_state <= ld_state_d;
      byte_idx <= byte_idx_d;
      asm_q    <= asm_d;
      n_q      <= n_d;
      wcnt_q   <= wcnt_d;
      r_we     <= we_d;
      r_addr   <= addr_d;
      r_din    <= din_d;
      r_busy   <= busy_d;
      r_done   <= done_d;
      r_err    <= err_d;
`ifdef LOADER_CSUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  // Loader: header word N, then N data words (then checksum when enabled)
  always_comb begin
    ld_state_d = ld_state;
    byte_idx_d = byte_idx;
    asm_d      = asm_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    we_d       = 1'b0;
    addr_d     = r_addr;
    din_d      = r_din;
    busy_d     = r_busy;
    done_d     = r_done;
    err_d      = r_err;
`ifdef LOADER_CSUM_EN
    acc_d      = acc_q;
`endif
    if (active_c) begin
      if (byte_valid) begin
        byte_idx_d = byte_idx + 2'd1;
        asm_d      = {rx_sh, asm_q[23:8]};
      end
      if (frame_err) begin
        ld_state_d = L_ERR;
        busy_d     = 1'b0;
        err_d      = 1'b1;
      end else if (word_last_c) begin
        case (ld_state)
          L_HDR: begin
            if (word_c == '0) begin
`ifdef LOADER_CSUM_EN
              ld_state_d = L_CSUM;
`else
              ld_state_d = L_DONE;
              busy_d     = 1'b0;
              done_d     = 1'b1;
`endif
            end else if (word_c > DW'(MAX_WORDS)) begin
              ld_state_d = L_ERR;
              busy_d     = 1'b0;
              err_d      = 1'b1;
            end else begin
              n_d        = NW'(word_c);
              wcnt_d     = '0;
              ld_state_d = L_DATA;
            end
          end
          L_DATA: begin
            we_d   = 1'b1;
            addr_d = AW'(wcnt_q);
            din_d  = word_c;
`ifdef LOADER_CSUM_EN
            acc_d  = acc_q + word_c;
`endif
            if (wcnt_q + NW'(1) == n_q) begin
`ifdef LOADER_CSUM_EN
              ld_state_d = L_CSUM;
`else
              ld_state_d = L_DONE;
              busy_d     = 1'b0;
              done_d     = 1'b1;
`endif
            end else begin
              wcnt_d = wcnt_q + NW'(1);
            end
          end
`ifdef LOADER_CSUM_EN
          L_CSUM: begin
            ld_state_d = (word_c == acc_q) ? L_DONE : L_ERR;
            busy_d     = 1'b0;
            done_d     = (word_c == acc_q);
            err_d      = (word_c != acc_q);
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_imem_loader.sv
// Self-checking bench for m_imem_loader: directed UART images against a queue-based write/status model.
module tb_m_imem_loader;
  localparam int unsigned WCNT = 8;
`ifdef LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        w_rxd;
  logic [11:0] r_addr;
  logic        r_we;
  logic [31:0] r_din;
  logic        r_busy, r_done, r_err;

  always #5 w_clk = ~w_clk;

  m_imem_loader #(.SERIAL_WCNT(WCNT), .MAX_WORDS(4096)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_rxd(w_rxd),
    .r_addr(r_addr), .r_we(r_we), .r_din(r_din),
    .r_busy(r_busy), .r_done(r_done), .r_err(r_err)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct packed { logic [11:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [11:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [31:0] img[$];
  logic [11:0] hold_a;
  logic [31:0] hold_d;

  // Model: sum of the first N data words present in the image
  function automatic logic [31:0] model_sum(input logic [31:0] q[$]);
    logic [31:0] s = '0;
    for (int i = 1; i < q.size() && i <= int'(q[0]); i++) s += q[i];
    return s;
  endfunction

  // Model: queue expected writes; return 0=still loading, 1=done, 2=error
  function automatic int model_image(input logic [31:0] q[$]);
    int n;
    if (q[0] > 32'd4096) return 2;
    n = int'(q[0]);
    for (int i = 0; i < n && i + 1 < q.size(); i++) exp_q.push_back('{a: 12'(i), d: q[i+1]});
    if (q.size() < n + 1) return 0;
    if (!CSUM) return 1;
    if (q.size() < n + 2) return 0;
    return (q[n+1] == model_sum(q)) ? 1 : 2;
  endfunction

  function automatic logic [31:0] st_bits(input int st);
    case (st)
      1:       return 32'b010;
      2:       return 32'b001;
      default: return 32'b100;
    endcase
  endfunction

  // Per-cycle compare against the model queue and the status invariant
  always @(negedge w_clk) begin
    if (!w_rst_n) begin
      hold_a = '0;
      hold_d = '0;
    end else begin
      check("status_onehot", 32'($onehot({r_busy, r_done, r_err})), 32'd1);
      if (r_we) begin
        wlog_a.push_back(r_addr);
        wlog_d.push_back(r_din);
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_write: addr 0x%03h din 0x%08h, expected no write", r_addr, r_din);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(r_addr), 32'(e.a));
          check("wr_din", r_din, e.d);
          hold_a = e.a;
          hold_d = e.d;
        end
      end else begin
        check("hold_addr", 32'(r_addr), 32'(hold_a));
        check("hold_din", r_din, hold_d);
      end
    end
  end

  task automatic do_reset();
    w_rxd   = 1'b1;
    w_rst_n = 1'b0;
    exp_q.delete();
    wlog_a.delete();
    wlog_d.delete();
    repeat (3) @(posedge w_clk);
    #1;
    check("rst_addr", 32'(r_addr), 32'd0);
    check("rst_we", 32'(r_we), 32'd0);
    check("rst_din", r_din, 32'd0);
    check("rst_status", 32'({r_busy, r_done, r_err}), 32'b100);
    w_rst_n = 1'b1;
    repeat (3) @(posedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    w_rxd = 1'b1;
    repeat (2) @(posedge w_clk);
    w_rxd = 1'b0;
    repeat (WCNT) @(posedge w_clk);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      repeat (WCNT) @(posedge w_clk);
    end
    w_rxd = stop;
    repeat (WCNT) @(posedge w_clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    w_rxd = 1'b1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    #1;
    while (r_busy && cyc < 40) begin
      @(posedge w_clk);
      #1;
      cyc++;
    end
  endtask

  // Sends img (plus its correct checksum when enabled and requested), then checks status
  task automatic run(input string name, input bit auto_csum, output int cyc);
    int st;
    if (CSUM && auto_csum) img.push_back(model_sum(img));
    st = model_image(img);
    foreach (img[i]) send_word(img[i]);
    wait_idle(cyc);
    check({name, "_status"}, 32'({r_busy, r_done, r_err}), st_bits(st));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    do_reset();

    // Two-word program, then stray bytes after completion
    img = {32'd2, 32'h20010020, 32'hAC010000};
    run("two_words", 1'b1, cyc);
    check("two_words_count", 32'(wlog_a.size()), 32'd2);
    check("two_words_a1", 32'(wlog_a[1]), 32'd1);
    check("two_words_d0", wlog_d[0], 32'h20010020);
    check("two_words_d1", wlog_d[1], 32'hAC010000);
    if (CSUM) check("two_words_csum_model", model_sum(img), 32'hCC020020);
    send_word(32'hFFFFFFFF);
    wait_idle(cyc);
    check("after_done_status", 32'({r_busy, r_done, r_err}), 32'b010);
    check("after_done_count", 32'(wlog_a.size()), 32'd2);

    // Empty image
    do_reset();
    img = {32'd0};
    run("n_zero", 1'b1, cyc);
    check("n_zero_latency", 32'(cyc <= 2), 32'd1);
    check("n_zero_done", 32'(r_done), 32'd1);
    check("n_zero_count", 32'(wlog_a.size()), 32'd0);

    // Framing error on the first data byte
    do_reset();
    send_word(32'd1);
    send_byte(8'h55, 1'b0);
    w_rxd = 1'b1;
    wait_idle(cyc);
    check("frame_status", 32'({r_busy, r_done, r_err}), 32'b001);
    check("frame_count", 32'(wlog_a.size()), 32'd0);

    // Header above memory depth
    do_reset();
    img = {32'd4097};
    run("too_big", 1'b0, cyc);
    check("too_big_err", 32'(r_err), 32'd1);

    // Short low glitch while idle must not shift byte alignment
    do_reset();
    w_rxd = 1'b0;
    repeat (3) @(posedge w_clk);
    w_rxd = 1'b1;
    repeat (40) @(posedge w_clk);
    #1;
    check("glitch_status", 32'({r_busy, r_done, r_err}), 32'b100);
    img = {32'd1, 32'hDEADBEEF};
    run("after_glitch", 1'b1, cyc);
    check("after_glitch_d0", wlog_d[0], 32'hDEADBEEF);
    check("after_glitch_a0", 32'(wlog_a[0]), 32'd0);

    // Reset in the middle of a load restarts at address 0
    do_reset();
    img = {32'd3, 32'h11111111};
    run("partial", 1'b0, cyc);
    check("partial_busy", 32'(r_busy), 32'd1);
    do_reset();
    img = {32'd1, 32'h12345678};
    run("reload", 1'b1, cyc);
    check("reload_count", 32'(wlog_a.size()), 32'd1);
    check("reload_a", 32'(wlog_a[0]), 32'd0);
    check("reload_d", wlog_d[0], 32'h12345678);

    if (CSUM) begin
      do_reset();
      img = {32'd2, 32'd5, 32'd7, 32'd12};
      run("csum_ok", 1'b0, cyc);
      check("csum_ok_done", 32'(r_done), 32'd1);
      do_reset();
      img = {32'd2, 32'd5, 32'd7, 32'd13};
      run("csum_bad", 1'b0, cyc);
      check("csum_bad_err", 32'(r_err), 32'd1);
      check("csum_bad_count", 32'(wlog_a.size()), 32'd2);
      check("csum_bad_d1", wlog_d[1], 32'd7);
    end

    repeat (5) @(posedge w_clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
